// File: rtl/div18x18_seq_if.sv
// Request/result bundle for the 18x18 sequential divider.
// The master side issues operands, and the slave side returns quotient, remainder and status.
interface div18x18_seq_if;
  logic        en;
  logic        start;
  logic        SIGNED;
  logic [17:0] A;
  logic [17:0] B;
  logic [17:0] Q;
  logic [17:0] R;
  logic        busy;
  logic        done;
  logic        dz;

  modport master (output en, start, SIGNED, A, B,
                  input  Q, R, busy, done, dz);
  modport slave  (input  en, start, SIGNED, A, B,
                  output Q, R, busy, done, dz);
endinterface

// File: rtl/div18x18_seq.sv
// Sequential 18-bit restoring divider, signed or unsigned.
// It takes 18 shift-subtract steps on magnitudes, then performs one sign-fix cycle.
module div18x18_seq (
  input  logic            clk,
  input  logic            rst,
  div18x18_seq_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  count;
  logic [18:0] rem;
  logic [17:0] quo;
  logic [17:0] b_mag;
  logic        signed_op;
  logic        neg_a;
  logic        neg_b;
  logic [17:0] q_reg;
  logic [17:0] r_reg;
  logic        dz_reg;

  logic [17:0] a_in_mag;
  logic [17:0] b_in_mag;
  logic [19:0] trial;
  logic        take;
  logic [17:0] q_fix;
  logic [17:0] r_fix;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (bus.en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start) state_nxt = RUN;
      RUN:  if (count == 5'd17) state_nxt = SIGN;
      SIGN: state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    a_in_mag = (bus.SIGNED && bus.A[17]) ? (~bus.A + 18'd1) : bus.A;
    b_in_mag = (bus.SIGNED && bus.B[17]) ? (~bus.B + 18'd1) : bus.B;
    trial    = {rem, quo[17]};
    take     = (trial >= {2'b00, b_mag});
    r_fix    = neg_a ? (~rem[17:0] + 18'd1) : rem[17:0];
    q_fix    = (neg_a ^ neg_b) ? (~quo + 18'd1) : quo;
    // A zero divisor saturates the quotient toward the sign of the dividend, and R falls out as A.
    if (b_mag == 18'd0) begin
      if (!signed_op)  q_fix = 18'h3FFFF;
      else if (neg_a)  q_fix = 18'h20000;
      else             q_fix = 18'h1FFFF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= 5'd0;
      rem       <= 19'd0;
      quo       <= 18'd0;
      b_mag     <= 18'd0;
      signed_op <= 1'b0;
      neg_a     <= 1'b0;
      neg_b     <= 1'b0;
      q_reg     <= 18'd0;
      r_reg     <= 18'd0;
      dz_reg    <= 1'b0;
    end else if (bus.en) begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            signed_op <= bus.SIGNED;
            neg_a     <= bus.SIGNED & bus.A[17];
            neg_b     <= bus.SIGNED & bus.B[17];
            quo       <= a_in_mag;
            b_mag     <= b_in_mag;
            rem       <= 19'd0;
            count     <= 5'd0;
          end
        end
        RUN: begin
          rem   <= take ? 19'(trial - {2'b00, b_mag}) : trial[18:0];
          quo   <= {quo[16:0], take};
          count <= count + 5'd1;
        end
        SIGN: begin
          q_reg  <= q_fix;
          r_reg  <= r_fix;
          dz_reg <= (b_mag == 18'd0);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.dz   = dz_reg;

endmodule

// File: doc/div18x18_seq.md
DIV18X18_SEQ -- requirements
Module: div18x18_seq

Interface
REQ-001 Parameter: none; the operand width is fixed at 18 bits and the iteration count at 18.
REQ-002 clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 en  input  1  clock enable; when low, all state, counters and outputs hold.
REQ-005 start  input  1  request; sampled only in IDLE with en=1.
REQ-006 SIGNED  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 A  input  18  dividend; sampled with start.
REQ-008 B  input  18  divisor; sampled with start.
REQ-009 Q  output  18  quotient, registered.
REQ-010 R  output  18  remainder, registered.
REQ-011 busy  output  1  high from the edge after start is accepted until return to IDLE.
REQ-012 done  output  1  one-cycle pulse; Q/R/dz valid from this cycle.
REQ-013 dz  output  1  divide-by-zero flag for the current result; valid with done.

Function
REQ-014 FSM states: IDLE, RUN, SIGN, DONE; every transition requires en=1.
REQ-015 IDLE with start=1 at edge t:
  - latch SIGNED, |A|, |B| (magnitudes when SIGNED=1, raw values otherwise) and the sign bits;
  - clear the 5-bit iteration counter; go to RUN.
REQ-016 RUN: one restoring shift-subtract step per enabled cycle, with an 19-bit partial remainder.
REQ-017 RUN: after the step with counter=17, go to SIGN; RUN therefore lasts exactly 18 enabled cycles.
REQ-018 SIGN (one cycle), signed mode:
  - negate the quotient when the sign of A differs from the sign of B;
  - negate the remainder when A is negative;
  - load Q/R/dz; go to DONE.
REQ-019 DONE: done=1 for exactly one cycle; go to IDLE on the next enabled edge.
REQ-020 With no en stalls, done is high in the cycle following edge t+19.
REQ-021 en stalls extend the latency by exactly the number of en=0 cycles.
REQ-022 Signed division truncates toward zero; the remainder takes the sign of the dividend; A = Q*B + R always holds for B != 0.
REQ-023 B=0 (the full latency still applies): dz=1, R=A, and Q is:
  - 18'h3FFFF in unsigned mode;
  - 18'h1FFFF in signed mode with A>=0;
  - 18'h20000 in signed mode with A<0.
REQ-024 Signed A=18'h20000 with B=18'h3FFFF: Q=18'h20000 (wraps), R=0, dz=0.
REQ-025 start while busy=1 or during DONE is ignored; no queuing.
REQ-026 start is accepted in the IDLE cycle immediately after DONE (back-to-back period 21 cycles).
REQ-027 Q, R and dz hold their last result until the next SIGN state.
REQ-028 busy is combinationally equal to (state != IDLE) and is registered-state derived only.

Reset
REQ-029 rst=1 forces IDLE asynchronously and clears: counter, partial remainder, Q=0, R=0, busy=0, done=0, dz=0.
REQ-030 rst asserted mid-operation aborts the division; no done pulse is issued for the aborted request.
REQ-031 The first start after rst deasserts is accepted normally.

Verification
REQ-032 SIGNED=1, A=100, B=7, start at edge t -> done in the cycle after t+19; Q=14, R=2, dz=0.
REQ-033 SIGNED=1, A=-100 (18'h3FF9C), B=7 -> Q=18'h3FFF2 (-14), R=18'h3FFFE (-2).
REQ-034 SIGNED=0, A=18'h3FFFF, B=2 -> Q=18'h1FFFF, R=1; then SIGNED=1, A=18'h20000, B=18'h3FFFF -> Q=18'h20000, R=0.
REQ-035 SIGNED=1, A=5, B=0 -> dz=1, Q=18'h1FFFF, R=5; the next division with B=3 -> dz=0.
REQ-036 en held low for 4 cycles during RUN -> done in the cycle after t+23, same Q/R; start pulsed while busy -> ignored.
REQ-037 rst pulsed at edge t+10 -> busy=0, Q=R=0 immediately, no done; new start with A=9, B=3 -> Q=3, R=0.
